// File: rtl/io_in_pkg.sv
// Shared types and helpers for the debounced input path.
// Event payloads are carried in a fixed-width struct and narrowed at the top-level ports.
package io_in_pkg;

    localparam int EV_IDX_MAX_W = 16;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    typedef struct packed {
        logic [EV_IDX_MAX_W-1:0] idx;
        logic                    level;
    } event_t;

endpackage

// File: rtl/io_debounce_bit.sv
// One input bit: multi-flop synchronizer, consecutive-mismatch counter, stable flop and edge pulses.
// flip is combinational and marks the edge at which stable will toggle.
module io_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   stable_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync;
    logic                   mismatch;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign mismatch = (sync != stable_q);
    assign flip     = mismatch && (cnt_q == CNT_MAX);

    // Any cycle where sync agrees with stable restarts the count, rejecting short glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            rise_q <= flip && !stable_q;
            fall_q <= flip &&  stable_q;
            if (!mismatch) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q    <= '0;
                stable_q <= ~stable_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/io_in_debounce.sv
// Debounces WIDTH asynchronous pins and serializes their level changes onto a valid/ready event port.
// Lowest pending index wins; re-flipping a still-pending bit sets the sticky overflow flag.
module io_in_debounce
    import io_in_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    localparam int IW             = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             event_valid_o,
    input  logic             event_ready_i,
    output logic [IW-1:0]    event_idx_o,
    output logic             event_level_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] clr;
    logic             load;
    logic             valid_q;
    logic             overflow_q;
    event_t           ev_sel;
    event_t           ev_q;
    logic             unused_ev_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        io_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin    (pin_i[i]),
            .stable (stable_o[i]),
            .rise   (rise_o[i]),
            .fall   (fall_o[i]),
            .flip   (flip[i])
        );
    end

    // Handshake: the payload transfers on any edge where event_valid_o && event_ready_i;
    // while valid is high and ready low, valid/idx/level are held unchanged.
    assign load = (!valid_q || event_ready_i) && (|pending_q);

    // Scan downward so the lowest set index is the one left selected.
    always_comb begin
        ev_sel = '0;
        clr    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                ev_sel.idx   = EV_IDX_MAX_W'(i);
                ev_sel.level = stable_o[i];
                clr          = '0;
                clr[i]       = load;
            end
        end
    end

    // A flip landing on the same edge as its capture re-arms pending without counting as lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            valid_q    <= 1'b0;
            ev_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~clr) | flip;
            if (|(flip & pending_q & ~clr)) begin
                overflow_q <= 1'b1;
            end
            if (load) begin
                valid_q <= 1'b1;
                ev_q    <= ev_sel;
            end else if (event_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign unused_ev_bits = ^ev_q.idx;

    assign event_valid_o = valid_q;
    assign event_idx_o   = ev_q.idx[IW-1:0];
    assign event_level_o = ev_q.level;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_io_in_debounce.sv
// Directed bench for io_in_debounce with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_io_in_debounce;

    localparam int WIDTH = 4;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] pin_i;
    logic [WIDTH-1:0] stable_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             event_valid_o;
    logic             event_ready_i;
    logic [IW-1:0]    event_idx_o;
    logic             event_level_o;
    logic             overflow_o;

    int n_asserts = 0;
    int n_fail    = 0;

    io_in_debounce #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pin_i         (pin_i),
        .stable_o      (stable_o),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_idx_o   (event_idx_o),
        .event_level_o (event_level_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_event(input string tag, input logic [IW-1:0] idx, input logic level);
        check({tag, "_valid"}, 32'(event_valid_o), 32'd1);
        check({tag, "_idx"},   32'(event_idx_o),   32'(idx));
        check({tag, "_level"}, 32'(event_level_o), 32'(level));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stable"},   32'(stable_o),      32'd0);
        check({tag, "_rise"},     32'(rise_o),        32'd0);
        check({tag, "_fall"},     32'(fall_o),        32'd0);
        check({tag, "_valid"},    32'(event_valid_o), 32'd0);
        check({tag, "_idx"},      32'(event_idx_o),   32'd0);
        check({tag, "_level"},    32'(event_level_o), 32'd0);
        check({tag, "_overflow"}, 32'(overflow_o),    32'd0);
    endtask

    initial begin
        // Reset with all pins already high.
        rst_n         = 1'b0;
        pin_i         = 4'b1111;
        event_ready_i = 1'b1;
        tick(3);
        check_all_zero("reset");

        rst_n = 1'b1;
        tick(5);
        check("pre_settle_stable", 32'(stable_o), 32'h0);
        tick(1);
        check("settle_stable", 32'(stable_o), 32'hf);
        check("settle_rise",   32'(rise_o),   32'hf);
        tick(1);
        check("settle_rise_gone", 32'(rise_o), 32'h0);
        check_event("up_ev0", 2'd0, 1'b1);
        tick(1);
        check_event("up_ev1", 2'd1, 1'b1);
        tick(1);
        check_event("up_ev2", 2'd2, 1'b1);
        tick(1);
        check_event("up_ev3", 2'd3, 1'b1);
        tick(1);
        check("up_drain_valid", 32'(event_valid_o), 32'd0);
        check("up_overflow",    32'(overflow_o),    32'd0);

        // All pins low again: four fall events.
        pin_i = 4'b0000;
        tick(5);
        check("down_pre_stable", 32'(stable_o), 32'hf);
        tick(1);
        check("down_stable", 32'(stable_o), 32'h0);
        check("down_fall",   32'(fall_o),   32'hf);
        for (int i = 0; i < WIDTH; i++) begin
            tick(1);
            check_event("down_ev", IW'(i), 1'b0);
        end
        tick(1);
        check("down_drain_valid", 32'(event_valid_o), 32'd0);

        // Glitch of three cycles on pin0 is rejected.
        pin_i = 4'b0001;
        tick(3);
        pin_i = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_stable", 32'(stable_o),      32'h0);
            check("glitch_rise",   32'(rise_o),        32'h0);
            check("glitch_valid",  32'(event_valid_o), 32'd0);
        end

        // Back-pressure: first event held while a second one queues.
        event_ready_i = 1'b0;
        pin_i = 4'b0100;
        tick(6);
        check("bp_stable", 32'(stable_o), 32'h4);
        check("bp_rise",   32'(rise_o),   32'h4);
        tick(1);
        check_event("bp_first", 2'd2, 1'b1);
        tick(9);
        pin_i = 4'b0110;
        tick(6);
        check("bp_stable2", 32'(stable_o), 32'h6);
        tick(3);
        check_event("bp_held", 2'd2, 1'b1);
        event_ready_i = 1'b1;
        tick(1);
        event_ready_i = 1'b0;
        check_event("bp_second", 2'd1, 1'b1);
        tick(2);
        check_event("bp_second_held", 2'd1, 1'b1);
        event_ready_i = 1'b1;
        tick(1);
        check("bp_drain_valid", 32'(event_valid_o), 32'd0);

        // Overflow: pin3 re-flips while its change is still pending.
        event_ready_i = 1'b0;
        pin_i = 4'b1110;
        tick(7);
        check_event("ovf_first", 2'd3, 1'b1);
        pin_i = 4'b0110;
        tick(6);
        check("ovf_mid_stable",   32'(stable_o),   32'h6);
        check("ovf_mid_overflow", 32'(overflow_o), 32'd0);
        check_event("ovf_mid_held", 2'd3, 1'b1);
        pin_i = 4'b1110;
        tick(6);
        check("ovf_stable",   32'(stable_o),   32'he);
        check("ovf_overflow", 32'(overflow_o), 32'd1);
        event_ready_i = 1'b1;
        tick(1);
        check_event("ovf_second", 2'd3, 1'b1);
        tick(1);
        check("ovf_drain_valid", 32'(event_valid_o), 32'd0);
        check("ovf_sticky",      32'(overflow_o),    32'd1);

        // Simultaneous rise on pins 0 and 3.
        pin_i = 4'b0110;
        tick(6);
        check("sim_prep_fall", 32'(fall_o), 32'h8);
        tick(1);
        check_event("sim_prep_ev", 2'd3, 1'b0);
        tick(1);
        pin_i = 4'b1111;
        tick(6);
        check("sim_stable", 32'(stable_o), 32'hf);
        check("sim_rise",   32'(rise_o),   32'h9);
        tick(1);
        check_event("sim_ev0", 2'd0, 1'b1);
        tick(1);
        check_event("sim_ev3", 2'd3, 1'b1);
        tick(1);
        check("sim_drain_valid", 32'(event_valid_o), 32'd0);

        // Asynchronous reset mid-handshake and mid-count.
        event_ready_i = 1'b0;
        pin_i = 4'b0111;
        tick(7);
        check_event("ar_pre", 2'd3, 1'b0);
        pin_i = 4'b0000;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick(2);
        rst_n = 1'b1;
        event_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("post_reset_valid",  32'(event_valid_o), 32'd0);
            check("post_reset_stable", 32'(stable_o),      32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/io_in_debounce.md
Name: io_in_debounce

Overview:
- Input-side counterpart of the counter/OBUF LED driver path.
- Takes WIDTH asynchronous pin levels after IBUF, synchronizes and debounces each bit, and exposes the stable levels with one-cycle edge pulses.
- Serializes level changes onto a valid/ready event port, lowest index first, with a sticky overflow flag.
- Sits between top-level IBUF outputs (buttons/switches) and fabric logic.

Parameters:
- WIDTH, 4, number of input pins.
- SYNC_STAGES, 2, synchronizer flops per bit (min 2).
- DEBOUNCE_CYCLES, 65536, consecutive cycles the synchronized value must differ from the stable value before the stable value flips (min 2).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- pin_i  input  WIDTH  raw asynchronous pin levels from IBUF outputs.
- stable_o  output  WIDTH  debounced levels.
- rise_o  output  WIDTH  one-cycle pulse when stable_o[i] goes 0->1.
- fall_o  output  WIDTH  one-cycle pulse when stable_o[i] goes 1->0.
- event_valid_o  output  1  event payload valid.
- event_ready_i  input  1  consumer accepts the event.
- event_idx_o  output  $clog2(WIDTH) (min 1)  bit index of the event.
- event_level_o  output  1  stable level of that bit at capture.
- overflow_o  output  1  sticky flag: an event was merged (lost).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all sync flops, stable_o, counters, pending, rise_o/fall_o, event_valid_o, event_idx_o, event_level_o and overflow_o go to 0 immediately on rst_n low, without waiting for a clock edge.
- Synchronizer: pin_i[i] passes through SYNC_STAGES flops, giving sync[i].
- Debounce counter per bit, width $clog2(DEBOUNCE_CYCLES):
  - sync[i]==stable[i]: counter cleared.
  - sync[i]!=stable[i] and counter<DEBOUNCE_CYCLES-1: counter increments.
  - sync[i]!=stable[i] and counter==DEBOUNCE_CYCLES-1: stable[i] flips at the next edge, counter clears, pending[i] sets.
  - Any mismatch gap restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: pin change held steady -> stable_o change after SYNC_STAGES+DEBOUNCE_CYCLES clock edges.
- Edge pulses: rise_o/fall_o are registered and high for exactly the one cycle in which stable_o shows the new value.
- Event register loads when (!event_valid_o || event_ready_i) and any pending bit is set:
  - selects the lowest pending index;
  - event_level_o takes the current stable[idx];
  - clears pending[idx];
  - event_valid_o=1 the cycle after pending sets.
- Throughput is one event per cycle while event_ready_i=1.
- If valid && !ready, event_valid_o, event_idx_o and event_level_o hold unchanged.
- Handshake with no pending bits: event_valid_o drops to 0 next cycle.
- Flip of bit i while pending[i] is already set: pending stays set, overflow_o=1 (sticky until reset); the reported level is the latest stable value.
- Flip of bit i in the same cycle that pending[i] is captured: set wins, pending[i] stays 1, no overflow.
- Simultaneous flips on several bits: all pending bits set; events are emitted in ascending index order.
- Reset asserted mid-count or mid-handshake: state is lost; no event is emitted for the aborted change.

Decomposition:
- Package io_in_pkg: helper function for index width (max(1,$clog2(WIDTH))); event struct {idx, level}.
- Sub-module io_debounce_bit (one-bit synchronizer + counter + stable flop + rise/fall/flip outputs), instantiated WIDTH times.
- The top level holds pending, the priority select, the event register and overflow.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Hold pin_i=4'b1111 through reset, release, ready=1 -> stable_o=4'b1111 6 edges after release, rise_o=4'b1111 for one cycle, events (idx,level) = (0,1),(1,1),(2,1),(3,1) on consecutive cycles, overflow_o=0.
- Pin0 high for 3 cycles then low -> stable_o, rise_o and event_valid_o stay 0.
- ready=0; pin2 rises, 10 cycles later pin1 rises -> valid with idx=2,level=1 held constant; raise ready for 1 cycle -> next event idx=1,level=1; then valid=0.
- ready=0; pin3 rises and is captured; pin3 falls, then rises again before ready -> overflow_o=1; ready=1 -> events (3,1) then (3,1).
- pin0 and pin3 rise in the same cycle, ready=1 -> events idx 0 then idx 3 in back-to-back cycles.
- Drop rst_n mid-count with valid=1, no clock edge -> all outputs 0 immediately; after release with pin_i=0 there are no events.
